stepper_controller: RTL and testbench

Sequences the stepper-motor driver pins (JA header) for the processor's IO subsystem. The CPU writes a target step position and a home command through memory-mapped registers (reg_24, reg_25); this block homes the axis against the limit switch, then steps the coils toward the target at a fixed rate and reports position, busy and fault status back to the CPU.

---
 rtl/stepper_controller.sv | 185 ++++++++++++++++++
 tb/tb_stepper_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_controller.sv
// Stepper-motor axis sequencer: homes against the limit switch, then steps the
// JA coil phases toward a clamped target position at a fixed step rate.
module stepper_controller #(
  parameter int              STEP_DIV = 100000,
  parameter int              POS_W    = 16,
  parameter logic [POS_W-1:0] MAX_POS  = 16'd4000,
  parameter logic [POS_W-1:0] HOME_MAX = 16'd6000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      target_pos,
  input  logic             cmd_home,
  input  logic             limit_switch,
  output logic [5:0]       ja,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             homed,
  output logic             fault
);

  localparam int TW = $clog2(STEP_DIV);
  localparam logic [TW-1:0]    TICK_AT = TW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] ONE     = POS_W'(1);
  localparam logic [POS_W-1:0] ZERO    = POS_W'(0);

  typedef enum logic [1:0] {
    UNHOMED = 2'd0,
    HOMING  = 2'd1,
    IDLE    = 2'd2,
    MOVING  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             lim_meta, lim_s, cmd_q, cmd_d;
  logic [TW-1:0]    timer, timer_n;
  logic [1:0]       phase, phase_n;
  logic [POS_W-1:0] step_cnt, cnt_n, pos_n, tgt, cnt_inc;
  logic             homed_n, fault_n, home_edge, tick, busy_n, energized_n;
  logic             tgt_unused;

  function automatic logic [3:0] coil(input logic [1:0] ph);
    case (ph)
      2'd0:    coil = 4'b0011;
      2'd1:    coil = 4'b0110;
      2'd2:    coil = 4'b1100;
      2'd3:    coil = 4'b1001;
      default: coil = 4'b0011;
    endcase
  endfunction

  assign tgt_unused = ^target_pos[31:POS_W];
  assign tgt        = (target_pos[POS_W-1:0] > MAX_POS) ? MAX_POS : target_pos[POS_W-1:0];
  assign home_edge  = cmd_q & ~cmd_d;
  assign tick       = (timer == TICK_AT);
  assign cnt_inc    = step_cnt + ONE;

  // Next-state, position, phase and status decisions.
  always_comb begin
    state_n = state;
    phase_n = phase;
    pos_n   = position;
    homed_n = homed;
    fault_n = fault;
    cnt_n   = step_cnt;
    case (state)
      UNHOMED: begin
        if (home_edge) begin
          fault_n = 1'b0;
          cnt_n   = ZERO;
          state_n = HOMING;
        end else begin
          state_n = UNHOMED;
        end
      end
      HOMING: begin
        if (home_edge) begin
          cnt_n = ZERO;
        end else if (tick) begin
          if (lim_s) begin
            pos_n   = ZERO;
            homed_n = 1'b1;
            state_n = IDLE;
          end else begin
            phase_n = phase - 2'd1;
            cnt_n   = cnt_inc;
            if (cnt_inc == HOME_MAX) begin
              fault_n = 1'b1;
              state_n = UNHOMED;
            end else begin
              state_n = HOMING;
            end
          end
        end else begin
          state_n = HOMING;
        end
      end
      IDLE: begin
        if (home_edge) begin
          homed_n = 1'b0;
          cnt_n   = ZERO;
          state_n = HOMING;
        end else if (tgt != position) begin
          state_n = MOVING;
        end else begin
          state_n = IDLE;
        end
      end
      MOVING: begin
        // A home request outranks any step due on the same tick.
        if (home_edge) begin
          homed_n = 1'b0;
          cnt_n   = ZERO;
          state_n = HOMING;
        end else if (tick) begin
          if (tgt == position) begin
            state_n = IDLE;
          end else if (tgt > position) begin
            pos_n   = position + ONE;
            phase_n = phase + 2'd1;
            state_n = (position + ONE == tgt) ? IDLE : MOVING;
          end else if (lim_s) begin
            pos_n   = ZERO;
            state_n = IDLE;
          end else begin
            pos_n   = position - ONE;
            phase_n = phase - 2'd1;
            state_n = (position - ONE == tgt) ? IDLE : MOVING;
          end
        end else begin
          state_n = MOVING;
        end
      end
      default: begin
        state_n = UNHOMED;
      end
    endcase
  end

  // Step timer restarts on every state change so each move gets a full first period.
  always_comb begin
    busy_n      = (state_n == HOMING) || (state_n == MOVING);
    energized_n = (state_n != UNHOMED);
    if (!busy_n || (state_n != state) || home_edge) begin
      timer_n = '0;
    end else if (tick) begin
      timer_n = '0;
    end else begin
      timer_n = timer + 1'b1;
    end
  end

  // Input synchronisers, state register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lim_meta <= 1'b0;
      lim_s    <= 1'b0;
      cmd_q    <= 1'b0;
      cmd_d    <= 1'b0;
      state    <= UNHOMED;
      timer    <= '0;
      phase    <= 2'd0;
      step_cnt <= ZERO;
      position <= ZERO;
      homed    <= 1'b0;
      fault    <= 1'b0;
      busy     <= 1'b0;
      ja       <= 6'b000000;
    end else begin
      lim_meta <= limit_switch;
      lim_s    <= lim_meta;
      cmd_q    <= cmd_home;
      cmd_d    <= cmd_q;
      state    <= state_n;
      timer    <= timer_n;
      phase    <= phase_n;
      step_cnt <= cnt_n;
      position <= pos_n;
      homed    <= homed_n;
      fault    <= fault_n;
      busy     <= busy_n;
      ja       <= energized_n ? {2'b11, coil(phase_n)} : 6'b000000;
    end
  end

endmodule

// File: tb/tb_stepper_controller.sv
// Scoreboard bench for stepper_controller with a 4-cycle step period, travel
// limit of 8 and homing limit of 6 reverse steps.
module tb_stepper_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] target_pos = 32'd10;
  logic        cmd_home = 1'b0;
  logic        limit_switch = 1'b0;
  logic [5:0]  ja;
  logic [15:0] position;
  logic        busy, homed, fault;

  stepper_controller #(
    .STEP_DIV(4), .POS_W(16), .MAX_POS(16'd8), .HOME_MAX(16'd6)
  ) dut (
    .clock(clock), .reset(reset), .target_pos(target_pos), .cmd_home(cmd_home),
    .limit_switch(limit_switch), .ja(ja), .position(position), .busy(busy),
    .homed(homed), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [24:0] v;
    int          at;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   probe_req = 0;
  int   probe_ack = 0;
  logic [24:0] last = 25'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input string tag, input logic [5:0] j, input int p,
                      input logic b, input logic h, input logic f, input int at);
    exp_t e;
    e.v   = {j, 16'(p), b, h, f};
    e.at  = at;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: any output change (or an explicit probe) consumes one expectation.
  initial begin
    exp_t        e;
    logic [24:0] cur;
    forever begin
      @(posedge clock or posedge reset);
      #2;
      cur = {ja, position, busy, homed, fault};
      if (cur !== last || probe_req != probe_ack) begin
        probe_ack = probe_req;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got ja=%b pos=%0d busy=%b homed=%b fault=%b, none expected",
                   cyc, ja, position, busy, homed, fault);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.at) begin
            errors++;
            $display("FAIL %s got ja=%b pos=%0d bhf=%b at cyc %0d, expected ja=%b pos=%0d bhf=%b at cyc %0d",
                     e.tag, ja, position, {busy, homed, fault}, cyc,
                     e.v[24:19], e.v[18:3], e.v[2:0], e.at);
          end
        end
      end
      last = cur;
    end
  end

  task automatic start(output int c);
    @(negedge clock);
    c = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d pending expectations, expected 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    int c;
    // Reset state, then confirm nothing moves without a home command.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    start(c);
    push("reset_state", 6'b000000, 0, 1'b0, 1'b0, 1'b0, c + 1);
    probe_req++;
    drain("reset");
    repeat (20) @(negedge clock);
    start(c);
    push("unhomed_idle", 6'b000000, 0, 1'b0, 1'b0, 1'b0, c + 1);
    probe_req++;
    drain("unhomed");

    // Home: four reverse steps, limit seen on the fifth tick.
    target_pos = 32'd0;
    start(c);
    cmd_home = 1'b1;
    push("home_entry", 6'b110011, 0, 1'b1, 1'b0, 1'b0, c + 2);
    push("home_rev1",  6'b111001, 0, 1'b1, 1'b0, 1'b0, c + 6);
    push("home_rev2",  6'b111100, 0, 1'b1, 1'b0, 1'b0, c + 10);
    push("home_rev3",  6'b110110, 0, 1'b1, 1'b0, 1'b0, c + 14);
    push("home_rev4",  6'b110011, 0, 1'b1, 1'b0, 1'b0, c + 18);
    push("home_done",  6'b110011, 0, 1'b0, 1'b1, 1'b0, c + 22);
    wait_until(c + 4);
    cmd_home = 1'b0;
    wait_until(c + 18);
    limit_switch = 1'b1;
    wait_until(c + 23);
    limit_switch = 1'b0;
    drain("home");

    // Forward move to 3.
    start(c);
    target_pos = 32'd3;
    push("fwd_start", 6'b110011, 0, 1'b1, 1'b1, 1'b0, c + 1);
    push("fwd_1",     6'b110110, 1, 1'b1, 1'b1, 1'b0, c + 5);
    push("fwd_2",     6'b111100, 2, 1'b1, 1'b1, 1'b0, c + 9);
    push("fwd_3",     6'b111001, 3, 1'b0, 1'b1, 1'b0, c + 13);
    drain("fwd");

    // Target beyond travel limit clamps to 8.
    start(c);
    target_pos = 32'd5000;
    push("clamp_start", 6'b111001, 3, 1'b1, 1'b1, 1'b0, c + 1);
    push("clamp_4",     6'b110011, 4, 1'b1, 1'b1, 1'b0, c + 5);
    push("clamp_5",     6'b110110, 5, 1'b1, 1'b1, 1'b0, c + 9);
    push("clamp_6",     6'b111100, 6, 1'b1, 1'b1, 1'b0, c + 13);
    push("clamp_7",     6'b111001, 7, 1'b1, 1'b1, 1'b0, c + 17);
    push("clamp_8",     6'b110011, 8, 1'b0, 1'b1, 1'b0, c + 21);
    drain("clamp");

    // Reverse to 4.
    start(c);
    target_pos = 32'd4;
    push("rev_start", 6'b110011, 8, 1'b1, 1'b1, 1'b0, c + 1);
    push("rev_7",     6'b111001, 7, 1'b1, 1'b1, 1'b0, c + 5);
    push("rev_6",     6'b111100, 6, 1'b1, 1'b1, 1'b0, c + 9);
    push("rev_5",     6'b110110, 5, 1'b1, 1'b1, 1'b0, c + 13);
    push("rev_4",     6'b110011, 4, 1'b0, 1'b1, 1'b0, c + 17);
    drain("rev");

    // Redirect mid-move; upper target bits are ignored.
    start(c);
    target_pos = 32'd10;
    push("redir_start", 6'b110011, 4, 1'b1, 1'b1, 1'b0, c + 1);
    push("redir_5",     6'b110110, 5, 1'b1, 1'b1, 1'b0, c + 5);
    push("redir_4",     6'b110011, 4, 1'b1, 1'b1, 1'b0, c + 9);
    push("redir_3",     6'b111001, 3, 1'b1, 1'b1, 1'b0, c + 13);
    push("redir_2",     6'b111100, 2, 1'b0, 1'b1, 1'b0, c + 17);
    wait_until(c + 5);
    target_pos = 32'hABCD_0002;
    drain("redir");

    // Limit and target reached on the same tick: limit wins, position 0.
    start(c);
    target_pos = 32'd1;
    limit_switch = 1'b1;
    push("lim_start", 6'b111100, 2, 1'b1, 1'b1, 1'b0, c + 1);
    push("lim_zero",  6'b111100, 0, 1'b0, 1'b1, 1'b0, c + 5);
    wait_until(c + 5);
    target_pos = 32'd0;
    limit_switch = 1'b0;
    drain("lim");

    // Home edge on a tick aborts the move; homing then times out.
    start(c);
    target_pos = 32'd4;
    push("abort_start", 6'b111100, 0, 1'b1, 1'b1, 1'b0, c + 1);
    push("abort_step",  6'b111001, 1, 1'b1, 1'b1, 1'b0, c + 5);
    push("abort_home",  6'b111001, 1, 1'b1, 1'b0, 1'b0, c + 9);
    push("to_rev1",     6'b111100, 1, 1'b1, 1'b0, 1'b0, c + 13);
    push("to_rev2",     6'b110110, 1, 1'b1, 1'b0, 1'b0, c + 17);
    push("to_rev3",     6'b110011, 1, 1'b1, 1'b0, 1'b0, c + 21);
    push("to_rev4",     6'b111001, 1, 1'b1, 1'b0, 1'b0, c + 25);
    push("to_rev5",     6'b111100, 1, 1'b1, 1'b0, 1'b0, c + 29);
    push("to_fault",    6'b000000, 1, 1'b0, 1'b0, 1'b1, c + 33);
    wait_until(c + 7);
    cmd_home = 1'b1;
    wait_until(c + 10);
    cmd_home = 1'b0;
    wait_until(c + 40);
    probe_req++;
    push("fault_hold",  6'b000000, 1, 1'b0, 1'b0, 1'b1, c + 41);
    drain("timeout");

    // New home clears fault; asynchronous reset mid-homing.
    start(c);
    cmd_home = 1'b1;
    push("rehome",      6'b110110, 1, 1'b1, 1'b0, 1'b0, c + 2);
    push("async_reset", 6'b000000, 0, 1'b0, 1'b0, 1'b0, c + 4);
    wait_until(c + 4);
    #1;
    reset = 1'b1;
    cmd_home = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drain("rehome");
    start(c);
    push("post_reset", 6'b000000, 0, 1'b0, 1'b0, 1'b0, c + 1);
    probe_req++;
    drain("post_reset");
    repeat (10) @(negedge clock);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
